// File: rtl/ysyx_220066_ifu_pkg.sv
// Shared frontend definitions: fetch FSM states, PC width, reset vector and NOP encoding.
package ysyx_220066_ifu_pkg;

    localparam int              PC_W         = 64;
    localparam logic [PC_W-1:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0]     INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~{{(PC_W-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/ysyx_220066_ifu_if.sv
// IFU bundle: EX redirect in, imem request/response, and ID valid/ready hand-off.
interface ysyx_220066_ifu_if;
    import ysyx_220066_ifu_pkg::*;

    logic            ex_redirect;
    logic [PC_W-1:0] ex_target;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rdata;

    logic            id_valid;
    logic            id_ready;
    logic [PC_W-1:0] id_pc;
    logic [31:0]     id_inst;
    logic            id_exc;

    modport master (
        input  ex_redirect, ex_target,
        input  imem_req_ready, imem_rsp_valid, imem_rdata,
        input  id_ready,
        output imem_req_valid, imem_addr,
        output id_valid, id_pc, id_inst, id_exc
    );

    modport slave (
        output ex_redirect, ex_target,
        output imem_req_ready, imem_rsp_valid, imem_rdata,
        output id_ready,
        input  imem_req_valid, imem_addr,
        input  id_valid, id_pc, id_inst, id_exc
    );

endinterface

// File: rtl/ysyx_220066_ifu.sv
// Fetch unit: one outstanding imem request, >=3 cycles per instruction, holds in HOLD while ID stalls.
// Optional IFU_MISALIGN_CHECK_EN: a misaligned redirect target yields an exception NOP instead of a fetch.
module ysyx_220066_ifu
    import ysyx_220066_ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    ysyx_220066_ifu_if.master io_bus
);

    ifu_state_e      r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_id_pc, w_id_pc_nxt;
    logic [31:0]     r_id_inst, w_id_inst_nxt;
    logic            r_id_vld, w_id_vld_nxt;
    logic            r_drop, w_drop_nxt;
    logic            r_req_vld, w_req_vld_nxt;
    logic [PC_W-1:0] w_tgt;
    logic            w_tgt_mis;
    logic            w_idle_nxt;
    logic            w_accept;
    logic            w_fire;

    assign w_accept = (r_state == ST_REQ) && r_req_vld && io_bus.imem_req_ready;
    assign w_fire   = (r_state == ST_HOLD) && r_id_vld && io_bus.id_ready && !io_bus.ex_redirect;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_idle, r_exc, w_exc_nxt;

    assign w_tgt      = io_bus.ex_target;
    assign w_tgt_mis  = |io_bus.ex_target[1:0];
    // After the exception NOP is consumed, stop fetching until EX steers us elsewhere.
    assign w_idle_nxt = io_bus.ex_redirect ? 1'b0 : ((w_fire && r_exc) ? 1'b1 : r_idle);
    assign w_exc_nxt  = io_bus.ex_redirect ? w_tgt_mis : (w_fire ? 1'b0 : r_exc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= 1'b0;
            r_exc  <= 1'b0;
        end else begin
            r_idle <= w_idle_nxt;
            r_exc  <= w_exc_nxt;
        end
    end

    assign io_bus.id_exc = r_exc;
`else
    assign w_tgt          = align_pc(io_bus.ex_target);
    assign w_tgt_mis      = 1'b0;
    assign w_idle_nxt     = 1'b0;
    assign io_bus.id_exc  = 1'b0;
`endif

    assign w_req_vld_nxt = (w_state_nxt == ST_REQ) && !w_idle_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_drop_nxt    = r_drop;
        w_id_vld_nxt  = r_id_vld;
        w_id_pc_nxt   = r_id_pc;
        w_id_inst_nxt = r_id_inst;

        // A stale response can only show up while a drop is pending; it retires the drop wherever we are.
        if (r_drop && io_bus.imem_rsp_valid) begin
            w_drop_nxt = 1'b0;
        end

        if (io_bus.ex_redirect) begin
            w_pc_nxt     = w_tgt;
            w_id_vld_nxt = 1'b0;
            case (r_state)
                ST_REQ: begin
                    if (w_accept) begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io_bus.imem_rsp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_REQ;
            endcase
            if (w_tgt_mis) begin
                w_state_nxt   = ST_HOLD;
                w_id_vld_nxt  = 1'b1;
                w_id_pc_nxt   = io_bus.ex_target;
                w_id_inst_nxt = INST_NOP;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_accept) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io_bus.imem_rsp_valid) begin
                        if (r_drop) begin
                            w_state_nxt = ST_REQ;
                        end else begin
                            w_id_vld_nxt  = 1'b1;
                            w_id_pc_nxt   = r_pc;
                            w_id_inst_nxt = io_bus.imem_rdata;
                            w_state_nxt   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_fire) begin
                        w_pc_nxt     = r_pc + 64'd4;
                        w_id_vld_nxt = 1'b0;
                        w_state_nxt  = ST_REQ;
                    end
                end
                default: w_state_nxt = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_REQ;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_req_vld <= 1'b0;
            r_id_vld  <= 1'b0;
            r_id_pc   <= '0;
            r_id_inst <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_drop    <= w_drop_nxt;
            r_req_vld <= w_req_vld_nxt;
            r_id_vld  <= w_id_vld_nxt;
            r_id_pc   <= w_id_pc_nxt;
            r_id_inst <= w_id_inst_nxt;
        end
    end

    assign io_bus.imem_req_valid = r_req_vld;
    assign io_bus.imem_addr      = r_pc;
    assign io_bus.id_valid       = r_id_vld;
    assign io_bus.id_pc          = r_id_pc;
    assign io_bus.id_inst        = r_id_inst;

endmodule

// File: tb/tb_ysyx_220066_ifu.sv
// Bench for ysyx_220066_ifu: directed cycle table, async reset sequence, then random traffic vs. a
// program-order model (delivered PCs follow pc+4 except where a redirect names the next PC).
module tb_ysyx_220066_ifu;

    localparam logic [63:0] A    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] T1   = 64'h0000_0000_8000_1000;
    localparam logic [63:0] T2   = 64'h0000_0000_8000_2000;
    localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] MIS  = 64'h0000_0000_8000_0002;
    localparam int          NV   = 26;

    typedef struct {
        bit          rdy;
        bit          rsp;
        logic [31:0] rdata;
        bit          idr;
        bit          redir;
        logic [63:0] tgt;
        bit          e_rv;
        logic [63:0] e_addr;
        bit          e_idv;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        bit          e_exc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    vec_t tbl [NV];

    ysyx_220066_ifu_if bus ();

    ysyx_220066_ifu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit rdy, bit rsp, logic [31:0] rdata, bit idr, bit redir,
                                logic [63:0] tgt, bit erv, logic [63:0] eaddr, bit eidv,
                                logic [63:0] epc, logic [31:0] einst, bit eexc);
        vec_t v;
        v.rdy = rdy;   v.rsp = rsp;     v.rdata = rdata; v.idr = idr;
        v.redir = redir; v.tgt = tgt;   v.e_rv = erv;    v.e_addr = eaddr;
        v.e_idv = eidv; v.e_pc = epc;   v.e_inst = einst; v.e_exc = eexc;
        return v;
    endfunction

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h9E37_79B9;
    endfunction

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input bit rdy, input bit rsp, input logic [31:0] rdata, input bit idr,
                         input bit redir, input logic [63:0] tgt);
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rdata     = rdata;
        bus.id_ready       = idr;
        bus.ex_redirect    = redir;
        bus.ex_target      = tgt;
    endtask

    // Random-phase state
    logic [63:0] exp_pc, paddr, prev_addr, tgt;
    logic [31:0] rdata;
    bit          pend, prev_rv, prev_acc, prev_redir, rdy, idr, redir, rsp, acc, fire;
    int          cnt, fires;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 64'h0);

        tbl[0]  = mk(1, 0, 32'h0,         0, 0, 64'h0, 0, A,     0, 64'h0, 32'h0,         0);
        tbl[1]  = mk(1, 0, 32'h0,         0, 0, 64'h0, 1, A,     0, 64'h0, 32'h0,         0);
        tbl[2]  = mk(0, 1, 32'h0000_0513, 0, 0, 64'h0, 0, A,     0, 64'h0, 32'h0,         0);
        tbl[3]  = mk(0, 0, 32'h0,         1, 0, 64'h0, 0, A,     1, A,     32'h0000_0513, 0);
        tbl[4]  = mk(1, 0, 32'h0,         0, 0, 64'h0, 1, A+4,   0, 64'h0, 32'h0,         0);
        tbl[5]  = mk(0, 1, 32'h0010_0093, 0, 0, 64'h0, 0, A+4,   0, 64'h0, 32'h0,         0);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(0, 0, 32'h0,      0, 0, 64'h0, 0, A+4,   1, A+4,   32'h0010_0093, 0);
        tbl[11] = mk(0, 0, 32'h0,         1, 0, 64'h0, 0, A+4,   1, A+4,   32'h0010_0093, 0);
        tbl[12] = mk(1, 0, 32'h0,         0, 0, 64'h0, 1, A+8,   0, 64'h0, 32'h0,         0);
        tbl[13] = mk(0, 0, 32'h0,         0, 1, T1,    0, A+8,   0, 64'h0, 32'h0,         0);
        tbl[14] = mk(0, 0, 32'h0,         0, 0, 64'h0, 0, T1,    0, 64'h0, 32'h0,         0);
        tbl[15] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0, 0, T1,    0, 64'h0, 32'h0,         0);
        tbl[16] = mk(1, 0, 32'h0,         0, 0, 64'h0, 1, T1,    0, 64'h0, 32'h0,         0);
        tbl[17] = mk(0, 1, 32'h0000_0073, 0, 0, 64'h0, 0, T1,    0, 64'h0, 32'h0,         0);
        tbl[18] = mk(0, 0, 32'h0,         1, 1, T2,    0, T1,    1, T1,    32'h0000_0073, 0);
        tbl[19] = mk(0, 0, 32'h0,         0, 1, WRAP,  1, T2,    0, 64'h0, 32'h0,         0);
        tbl[20] = mk(1, 0, 32'h0,         0, 0, 64'h0, 1, WRAP,  0, 64'h0, 32'h0,         0);
        tbl[21] = mk(0, 1, 32'h1234_5678, 0, 0, 64'h0, 0, WRAP,  0, 64'h0, 32'h0,         0);
        tbl[22] = mk(0, 0, 32'h0,         1, 0, 64'h0, 0, WRAP,  1, WRAP,  32'h1234_5678, 0);
        tbl[23] = mk(1, 0, 32'h0,         0, 1, MIS,   1, 64'h0, 0, 64'h0, 32'h0,         0);
`ifdef IFU_MISALIGN_CHECK_EN
        tbl[24] = mk(0, 1, 32'h0000_0BAD, 1, 0, 64'h0, 0, MIS,   1, MIS,   32'h0000_0013, 1);
        tbl[25] = mk(0, 0, 32'h0,         0, 0, 64'h0, 0, MIS+4, 0, 64'h0, 32'h0,         0);
`else
        tbl[24] = mk(0, 1, 32'h0000_0BAD, 0, 0, 64'h0, 0, A,     0, 64'h0, 32'h0,         0);
        tbl[25] = mk(0, 0, 32'h0,         0, 0, 64'h0, 1, A,     0, 64'h0, 32'h0,         0);
`endif

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check64("reset.req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check64("reset.imem_addr", bus.imem_addr, A);
        check64("reset.id_valid",  {63'd0, bus.id_valid}, 64'd0);
        check64("reset.id_pc",     bus.id_pc, 64'd0);
        check64("reset.id_inst",   {32'd0, bus.id_inst}, 64'd0);
        check64("reset.id_exc",    {63'd0, bus.id_exc}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            check64($sformatf("vec%0d.req_valid", i), {63'd0, bus.imem_req_valid}, {63'd0, tbl[i].e_rv});
            check64($sformatf("vec%0d.imem_addr", i), bus.imem_addr, tbl[i].e_addr);
            check64($sformatf("vec%0d.id_valid", i),  {63'd0, bus.id_valid}, {63'd0, tbl[i].e_idv});
            check64($sformatf("vec%0d.id_exc", i),    {63'd0, bus.id_exc}, {63'd0, tbl[i].e_exc});
            if (tbl[i].e_idv) begin
                check64($sformatf("vec%0d.id_pc", i),   bus.id_pc, tbl[i].e_pc);
                check64($sformatf("vec%0d.id_inst", i), {32'd0, bus.id_inst}, {32'd0, tbl[i].e_inst});
            end
            drive(tbl[i].rdy, tbl[i].rsp, tbl[i].rdata, tbl[i].idr, tbl[i].redir, tbl[i].tgt);
            @(negedge clk);
        end

        // Reset mid-transaction, then a late response while back in REQ must be ignored.
        drive(1, 0, 32'h0, 0, 0, 64'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 64'h0);
        #2 rst_n = 1'b0;
        #1;
        check64("arst.req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check64("arst.id_valid",  {63'd0, bus.id_valid}, 64'd0);
        check64("arst.imem_addr", bus.imem_addr, A);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 32'h0BAD_0BAD, 1, 0, 64'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 64'h0);
        check64("late_rsp.id_valid",  {63'd0, bus.id_valid}, 64'd0);
        check64("late_rsp.req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check64("late_rsp.imem_addr", bus.imem_addr, A);

        exp_pc = A; pend = 0; prev_rv = 0; prev_acc = 0; prev_redir = 0; prev_addr = '0;
        fires = 0; cnt = 0; paddr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_rv && !prev_acc && !prev_redir) begin
                check64("req_stable.valid", {63'd0, bus.imem_req_valid}, 64'd1);
                check64("req_stable.addr",  bus.imem_addr, prev_addr);
            end
            rdy   = ($urandom_range(0, 9) < 7);
            idr   = ($urandom_range(0, 9) < 6);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = {$urandom, $urandom};
`ifdef IFU_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            rsp   = 0;
            rdata = $urandom;
            if (pend) begin
                if (cnt == 0) begin
                    rsp   = 1;
                    rdata = memfn(paddr);
                    pend  = 0;
                end else begin
                    cnt--;
                end
            end
            acc  = bus.imem_req_valid && rdy;
            fire = bus.id_valid && idr && !redir;
            if (acc) begin
                check64("fetch_addr", bus.imem_addr, exp_pc);
                check64("one_outstanding", {63'd0, pend}, 64'd0);
                pend  = 1;
                paddr = bus.imem_addr;
                cnt   = $urandom_range(0, 2);
            end
            if (fire) begin
                check64("deliver.id_pc",   bus.id_pc, exp_pc);
                check64("deliver.id_inst", {32'd0, bus.id_inst}, {32'd0, memfn(exp_pc)});
                exp_pc = exp_pc + 64'd4;
                fires++;
            end
            if (redir) exp_pc = tgt & ~64'h3;
            prev_rv    = bus.imem_req_valid;
            prev_acc   = acc;
            prev_redir = redir;
            prev_addr  = bus.imem_addr;
            drive(rdy, rsp, rdata, idr, redir, tgt);
            @(negedge clk);
        end
        check64("random.progress", {63'd0, fires > 100}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
